scope_capture_engine: RTL

- Parametrised capture-and-dump engine for the scope digital core. Generalises the fixed 3-channel, 512-deep ADC capture path to NUM_CH channels and 2^ADDR_W depth, and adds selectable trigger channel and polarity, force-trigger, decimation, and a ready/valid dump stream.
- Writes all channels into shared-address circular RAM. Arms, triggers with a programmable post-trigger count, then streams a selected channel oldest-first to the command/UART side.

---
 rtl/scope_capture_engine_if.sv | 25 ++
 rtl/scope_capture_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/scope_capture_engine_if.sv
// RAM access bus and dump byte stream of the scope capture engine.
// The engine drives the master side; the RAM and the dump consumer sit on the slave side.
interface scope_capture_engine_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
);
  logic                     ram_en;
  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_addr;
  logic [NUM_CH*DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0]        out_data;
  logic                     out_vld;
  logic                     out_rdy;

  modport master (
    output ram_en, ram_we, ram_addr, out_data, out_vld,
    input  ram_rdata, out_rdy
  );

  modport slave (
    input  ram_en, ram_we, ram_addr, out_data, out_vld,
    output ram_rdata, out_rdy
  );
endinterface

// File: rtl/scope_capture_engine.sv
// Multi-channel circular capture engine: decimated writes into a shared-address RAM,
// pre/post-trigger sequencing with edge or forced trigger, and an oldest-first
// ready/valid dump of one selected channel.
module scope_capture_engine #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEC_W  = 8,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  smpl_en,
  input  logic [NUM_CH-1:0]     trig_vec,
  input  logic [CH_W-1:0]       trig_sel,
  input  logic                  trig_pol,
  input  logic                  force_trig,
  input  logic                  arm,
  input  logic [ADDR_W-1:0]     trig_pos,
  input  logic [DEC_W-1:0]      dec_div,
  input  logic                  dump_req,
  input  logic [CH_W-1:0]       dump_ch,
  scope_capture_engine_if.master bus,
  output logic                  capture_done,
  output logic [ADDR_W-1:0]     trig_addr,
  output logic                  dump_done
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);

  typedef enum logic [2:0] {
    StIdle, StPre, StArmed, StPost, StDone, StDumpRd, StDumpHold
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEC_W-1:0]    dec_cnt_q, dec_cnt_d;
  logic [ADDR_W:0]     pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_vld_q, out_vld_d;
  logic                capture_done_q, capture_done_d;
  logic                dump_done_q, dump_done_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                prev_q, prev_d;

  logic                trig_cur;
  logic                trig_hit;
  logic                capturing;
  logic                wr_fire;
  logic [DATA_W-1:0]   rd_slice;

  // Select the trigger channel and the dump channel slice; out-of-range indices read as 0.
  always_comb begin
    trig_cur = 1'b0;
    rd_slice = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (trig_sel == CH_W'(i)) trig_cur = trig_vec[i];
      if (ch_q == CH_W'(i))     rd_slice = bus.ram_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign trig_hit  = (trig_pol ? (trig_cur & ~prev_q) : (~trig_cur & prev_q)) | force_trig;
  assign capturing = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
  assign wr_fire   = capturing && smpl_en && (dec_cnt_q == '0);

  // RAM strobes follow the current state so a sample is written in its own smpl_en clock.
  assign bus.ram_en   = wr_fire || (state_q == StDumpRd);
  assign bus.ram_we   = wr_fire;
  assign bus.ram_addr = (state_q == StDumpRd) ? rd_ptr_q : wr_ptr_q;
  assign bus.out_data = out_data_q;
  assign bus.out_vld  = out_vld_q;
  assign capture_done = capture_done_q;
  assign trig_addr    = trig_addr_q;
  assign dump_done    = dump_done_q;

  // Next-state computation for the sequencer, pointers, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    dec_cnt_d    = dec_cnt_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    cnt_d        = cnt_q;
    trig_addr_d  = trig_addr_q;
    out_data_d   = out_data_q;
    out_vld_d    = out_vld_q;
    ch_d         = ch_q;
    dump_done_d  = 1'b0;
    prev_d       = trig_cur;

    if (capturing && smpl_en) begin
      dec_cnt_d = (dec_cnt_q == '0) ? dec_div : dec_cnt_q - DEC_W'(1);
    end
    if (wr_fire) wr_ptr_d = wr_ptr_q + ADDR_W'(1);

    unique case (state_q)
      StPre: begin
        // Triggers are deliberately not latched while the pre-trigger window fills.
        if (wr_fire) begin
          pre_cnt_d = pre_cnt_q - (ADDR_W + 1)'(1);
          if (pre_cnt_q == (ADDR_W + 1)'(1)) state_d = StArmed;
        end
      end
      StArmed: begin
        if (trig_hit) begin
          // A write in the trigger clock belongs to the pre-trigger history.
          trig_addr_d = wr_ptr_d;
          post_cnt_d  = trig_pos;
          state_d     = (trig_pos == '0) ? StDone : StPost;
        end
      end
      StPost: begin
        if (wr_fire) begin
          post_cnt_d = post_cnt_q - ADDR_W'(1);
          if (post_cnt_q == ADDR_W'(1)) state_d = StDone;
        end
      end
      StDone: begin
        if (dump_req && (32'(dump_ch) < NUM_CH)) begin
          ch_d     = dump_ch;
          rd_ptr_d = wr_ptr_q;
          cnt_d    = DepthCnt;
          state_d  = StDumpRd;
        end
      end
      StDumpRd: state_d = StDumpHold;
      StDumpHold: begin
        if (!out_vld_q) begin
          // RAM data for the read issued last clock is valid now.
          out_data_d = rd_slice;
          out_vld_d  = 1'b1;
        end else if (bus.out_rdy) begin
          out_vld_d = 1'b0;
          rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
          cnt_d     = cnt_q - (ADDR_W + 1)'(1);
          if (cnt_q == (ADDR_W + 1)'(1)) begin
            dump_done_d = 1'b1;
            state_d     = StDone;
          end else begin
            state_d = StDumpRd;
          end
        end
      end
      default: ;
    endcase

    // Arm restarts capture from any non-dump state and beats a same-clock dump request.
    if (arm && (state_q != StDumpRd) && (state_q != StDumpHold)) begin
      state_d   = StPre;
      pre_cnt_d = DepthCnt - {1'b0, trig_pos};
      dec_cnt_d = '0;
    end

    capture_done_d = (state_d == StDone) || (state_d == StDumpRd) || (state_d == StDumpHold);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      dec_cnt_q      <= '0;
      pre_cnt_q      <= '0;
      post_cnt_q     <= '0;
      cnt_q          <= '0;
      trig_addr_q    <= '0;
      out_data_q     <= '0;
      out_vld_q      <= 1'b0;
      capture_done_q <= 1'b0;
      dump_done_q    <= 1'b0;
      ch_q           <= '0;
      prev_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      dec_cnt_q      <= dec_cnt_d;
      pre_cnt_q      <= pre_cnt_d;
      post_cnt_q     <= post_cnt_d;
      cnt_q          <= cnt_d;
      trig_addr_q    <= trig_addr_d;
      out_data_q     <= out_data_d;
      out_vld_q      <= out_vld_d;
      capture_done_q <= capture_done_d;
      dump_done_q    <= dump_done_d;
      ch_q           <= ch_d;
      prev_q         <= prev_d;
    end
  end

endmodule
